// File: rtl/mor1kx_bpu_pkg.sv
// Shared types and helpers for the mor1kx branch predictor PHT controller.
// State encoding, 2-bit counter constants and the saturating counter step.
package mor1kx_bpu_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  function automatic logic [1:0] sat_next(
    input logic [1:0] cnt,
    input logic       taken
  );
    if (taken)
      return (cnt == STRONG_T) ? STRONG_T : cnt + 2'd1;
    return (cnt == STRONG_NT) ? STRONG_NT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/mor1kx_bpu_upd_fifo.sv
// Update buffer for the PHT controller: index + counter per entry.
// All entries and the read pointer are exposed for lookup forwarding.
module mor1kx_bpu_upd_fifo
  import mor1kx_bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [IDX_W-1:0]            push_idx,
  input  logic [1:0]                  push_cnt,
  input  logic                        pop,
  output logic [IDX_W-1:0]            head_idx,
  output logic [1:0]                  head_cnt,
  output logic [PW:0]                 count,
  output logic                        full,
  output logic                        empty,
  output logic [PW-1:0]               rptr,
  output logic [DEPTH-1:0][IDX_W-1:0] ent_idx,
  output logic [DEPTH-1:0][1:0]       ent_cnt
);

  logic [PW-1:0] wptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ent_idx[wptr] <= push_idx;
        ent_cnt[wptr] <= push_cnt;
        wptr          <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_idx = ent_idx[rptr];
  assign head_cnt = ent_cnt[rptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/mor1kx_bpu_pht_ctrl.sv
// Single-port PHT RAM controller: init sweep, lookup/update arbitration.
// Define MOR1KX_BPU_PHT_FWD_EN to forward queued updates to lookups.
module mor1kx_bpu_pht_ctrl
  import mor1kx_bpu_pkg::*;
#(
  parameter int         INDEX_WIDTH    = 6,
  parameter int         UPD_FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VALUE     = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready_o,
  input  logic                   lookup_req_i,
  input  logic [INDEX_WIDTH-1:0] lookup_idx_i,
  output logic                   lookup_gnt_o,
  output logic                   lookup_valid_o,
  output logic [1:0]             lookup_cnt_o,
  input  logic                   upd_valid_i,
  input  logic [INDEX_WIDTH-1:0] upd_idx_i,
  input  logic [1:0]             upd_old_cnt_i,
  input  logic                   upd_taken_i,
  output logic                   upd_ready_o,
  output logic                   ram_en_o,
  output logic                   ram_we_o,
  output logic [INDEX_WIDTH-1:0] ram_addr_o,
  output logic [1:0]             ram_wdata_o,
  input  logic [1:0]             ram_rdata_i
);

  localparam int PW = $clog2(UPD_FIFO_DEPTH);

  state_t                   state_q;
  logic [INDEX_WIDTH-1:0]   init_q;
  logic                     run, init;
  logic                     gnt, push, pop;
  logic                     full, empty;
  logic                     vld_q;
  logic [1:0]               hold_q, rd_cnt;
  logic [1:0]               push_cnt, head_cnt;
  logic [INDEX_WIDTH-1:0]   head_idx;
  logic [PW:0]              count;
  logic [PW-1:0]            rptr;
  logic [UPD_FIFO_DEPTH-1:0][INDEX_WIDTH-1:0] ent_idx;
  logic [UPD_FIFO_DEPTH-1:0][1:0]             ent_cnt;

  assign init        = rst && (state_q == ST_INIT);
  assign run         = rst && (state_q == ST_RUN);
  assign ready_o     = run;
  assign upd_ready_o = run && !full;
  assign push        = upd_valid_i && upd_ready_o;
  assign push_cnt    = sat_next(upd_old_cnt_i, upd_taken_i);
  // Lookups win unless the buffer is full, then one drain slot is forced.
  assign gnt          = run && lookup_req_i && !full;
  assign pop          = run && !gnt && !empty;
  assign lookup_gnt_o = gnt;

  mor1kx_bpu_upd_fifo #(
    .DEPTH (UPD_FIFO_DEPTH),
    .IDX_W (INDEX_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (upd_idx_i),
    .push_cnt (push_cnt),
    .pop      (pop),
    .head_idx (head_idx),
    .head_cnt (head_cnt),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .rptr     (rptr),
    .ent_idx  (ent_idx),
    .ent_cnt  (ent_cnt)
  );

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = lookup_idx_i;
    ram_wdata_o = head_cnt;
    unique case (1'b1)
      init: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = init_q;
        ram_wdata_o = INIT_VALUE;
      end
      gnt: begin
        ram_en_o = 1'b1;
      end
      pop: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = head_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      vld_q   <= 1'b0;
      hold_q  <= 2'b00;
    end else begin
      if (state_q == ST_INIT) begin
        init_q <= init_q + 1'b1;
        if (&init_q)
          state_q <= ST_RUN;
      end
      vld_q <= gnt;
      if (vld_q)
        hold_q <= rd_cnt;
    end
  end

`ifdef MOR1KX_BPU_PHT_FWD_EN
  logic          fwd_hit, fwd_hit_q;
  logic [1:0]    fwd_cnt, fwd_cnt_q;
  logic [PW-1:0] pos;

  // Scan oldest to youngest so the last hit is the youngest entry.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_cnt = 2'b00;
    pos     = rptr;
    for (int k = 0; k < UPD_FIFO_DEPTH; k++) begin
      pos = rptr + PW'(k);
      if (((PW+1)'(k) < count) && (ent_idx[pos] == lookup_idx_i)) begin
        fwd_hit = 1'b1;
        fwd_cnt = ent_cnt[pos];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_hit_q <= 1'b0;
      fwd_cnt_q <= 2'b00;
    end else if (gnt) begin
      fwd_hit_q <= fwd_hit;
      fwd_cnt_q <= fwd_cnt;
    end
  end

  assign rd_cnt = fwd_hit_q ? fwd_cnt_q : ram_rdata_i;
`else
  logic fwd_unused;
  assign fwd_unused = ^{count, rptr, ent_idx, ent_cnt};
  assign rd_cnt     = ram_rdata_i;
`endif

  assign lookup_valid_o = rst && vld_q;
  assign lookup_cnt_o   = !rst ? 2'b00 : (vld_q ? rd_cnt : hold_q);

endmodule

// File: tb/tb_mor1kx_bpu_pht_ctrl.sv
// Self-checking bench for mor1kx_bpu_pht_ctrl with a behavioural RAM.
// Reference model: pending-update queue plus a plain PHT array.
module tb_mor1kx_bpu_pht_ctrl;

  localparam int IW = 6;
  localparam int D  = 4;
  localparam int N  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready_o;
  logic          lookup_req_i;
  logic [IW-1:0] lookup_idx_i;
  logic          lookup_gnt_o;
  logic          lookup_valid_o;
  logic [1:0]    lookup_cnt_o;
  logic          upd_valid_i;
  logic [IW-1:0] upd_idx_i;
  logic [1:0]    upd_old_cnt_i;
  logic          upd_taken_i;
  logic          upd_ready_o;
  logic          ram_en_o;
  logic          ram_we_o;
  logic [IW-1:0] ram_addr_o;
  logic [1:0]    ram_wdata_o;
  logic [1:0]    ram_rdata_i = 2'b00;

  always #5 clk = ~clk;

  mor1kx_bpu_pht_ctrl #(
    .INDEX_WIDTH    (IW),
    .UPD_FIFO_DEPTH (D),
    .INIT_VALUE     (2'b01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ready_o        (ready_o),
    .lookup_req_i   (lookup_req_i),
    .lookup_idx_i   (lookup_idx_i),
    .lookup_gnt_o   (lookup_gnt_o),
    .lookup_valid_o (lookup_valid_o),
    .lookup_cnt_o   (lookup_cnt_o),
    .upd_valid_i    (upd_valid_i),
    .upd_idx_i      (upd_idx_i),
    .upd_old_cnt_i  (upd_old_cnt_i),
    .upd_taken_i    (upd_taken_i),
    .upd_ready_o    (upd_ready_o),
    .ram_en_o       (ram_en_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  logic [1:0] mem [N];

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o)
        mem[ram_addr_o] <= ram_wdata_o;
      else
        ram_rdata_i <= mem[ram_addr_o];
    end
  end

  typedef struct {
    logic [IW-1:0] idx;
    logic [1:0]    cnt;
  } upd_t;

  upd_t       q[$];
  logic [1:0] pht_m [N];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [1:0] sat(input int old, input bit taken);
    int n;
    n = taken ? old + 1 : old - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    return 2'(n);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    lookup_req_i  = 1'b0;
    lookup_idx_i  = '0;
    upd_valid_i   = 1'b0;
    upd_idx_i     = '0;
    upd_old_cnt_i = 2'b00;
    upd_taken_i   = 1'b0;
  endtask

  task automatic do_init();
    bit ok;
    ok = 1'b0;
    idle_in();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL init_timeout: ready_o=%b required 1", ready_o);
    end
    cyc();
    q.delete();
    for (int i = 0; i < N; i++) pht_m[i] = 2'b01;
  endtask

  task automatic test_reset();
    logic [6:0]  a7, e7;
    logic [12:0] a13, e13;
    idle_in();
    lookup_req_i = 1'b1;
    upd_valid_i  = 1'b1;
    rst = 1'b0;
    cyc();
    @(negedge clk);
    a7 = {ready_o, lookup_gnt_o, lookup_valid_o, lookup_cnt_o,
          upd_ready_o, ram_en_o};
    e7 = '0;
    vectors++;
    if (a7 !== e7 || ram_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b we=%b required %b we=0",
               a7, ram_we_o, e7);
    end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      a13 = {ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
             ready_o, lookup_gnt_o, upd_ready_o};
      e13 = {1'b1, 1'b1, 6'(i), 2'b01, 3'b000};
      vectors++;
      if (a13 !== e13) begin
        miscompares++;
        $display("FAIL sweep[%0d]: got %b required %b", i, a13, e13);
      end
      cyc();
    end
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_rise: got %b required 1", ready_o);
    end
    cyc();
    idle_in();
  endtask

  task automatic test_reset_restart();
    idle_in();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ram_en_o !== 1'b0 || ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: en=%b ready=%b required 0 0",
               ram_en_o, ready_o);
    end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vectors++;
      if (ram_en_o !== 1'b1 || ram_we_o !== 1'b1 ||
          ram_addr_o !== 6'(i)) begin
        miscompares++;
        $display("FAIL restart[%0d]: en=%b we=%b addr=%0d required 1 1 %0d",
                 i, ram_en_o, ram_we_o, ram_addr_o, i);
      end
      cyc();
    end
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_ready: got %b required 1", ready_o);
    end
    cyc();
  endtask

  task automatic test_lookup_idle();
    do_init();
    lookup_req_i = 1'b1;
    lookup_idx_i = 6'd5;
    @(negedge clk);
    vectors++;
    if ({lookup_gnt_o, ram_en_o, ram_we_o, ram_addr_o} !==
        {1'b1, 1'b1, 1'b0, 6'd5}) begin
      miscompares++;
      $display("FAIL lookup_gnt: gnt=%b en=%b we=%b addr=%0d required 1 1 0 5",
               lookup_gnt_o, ram_en_o, ram_we_o, ram_addr_o);
    end
    cyc();
    lookup_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({lookup_valid_o, lookup_cnt_o} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL lookup_ret: valid=%b cnt=%0d required 1 1",
               lookup_valid_o, lookup_cnt_o);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if ({lookup_valid_o, lookup_cnt_o} !== {1'b0, 2'd1}) begin
      miscompares++;
      $display("FAIL lookup_hold: valid=%b cnt=%0d required 0 1",
               lookup_valid_o, lookup_cnt_o);
    end
    cyc();
  endtask

  task automatic test_saturation();
    int olds [3] = '{3, 0, 1};
    bit tks  [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] e;
    do_init();
    for (int t = 0; t < 3; t++) begin
      upd_valid_i   = 1'b1;
      upd_idx_i     = 6'd3;
      upd_old_cnt_i = 2'(olds[t]);
      upd_taken_i   = tks[t];
      e = sat(olds[t], tks[t]);
      @(negedge clk);
      vectors++;
      if (upd_ready_o !== 1'b1 || ram_en_o !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_push[%0d]: ready=%b en=%b required 1 0",
                 t, upd_ready_o, ram_en_o);
      end
      cyc();
      upd_valid_i = 1'b0;
      @(negedge clk);
      vectors++;
      if ({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o} !==
          {1'b1, 1'b1, 6'd3, e}) begin
        miscompares++;
        $display("FAIL sat_write[%0d]: en=%b we=%b addr=%0d data=%0d required 1 1 3 %0d",
                 t, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, e);
      end
      cyc();
    end
  endtask

  task automatic test_full();
    logic [1:0] e;
    do_init();
    lookup_req_i = 1'b1;
    lookup_idx_i = 6'd10;
    for (int c = 0; c < 4; c++) begin
      upd_valid_i   = 1'b1;
      upd_idx_i     = 6'(20 + c);
      upd_old_cnt_i = 2'd1;
      upd_taken_i   = c[0];
      @(negedge clk);
      vectors++;
      if ({upd_ready_o, lookup_gnt_o, ram_en_o, ram_we_o} !== 4'b1110) begin
        miscompares++;
        $display("FAIL full_fill[%0d]: rdy/gnt/en/we=%b required 1110",
                 c, {upd_ready_o, lookup_gnt_o, ram_en_o, ram_we_o});
      end
      cyc();
    end
    upd_valid_i = 1'b0;
    e = sat(1, 1'b0);
    @(negedge clk);
    vectors++;
    if ({upd_ready_o, lookup_gnt_o, ram_en_o, ram_we_o, ram_addr_o,
         ram_wdata_o} !== {4'b0011, 6'd20, e}) begin
      miscompares++;
      $display("FAIL full_drain: rdy=%b gnt=%b en=%b we=%b addr=%0d data=%0d required 0 0 1 1 20 %0d",
               upd_ready_o, lookup_gnt_o, ram_en_o, ram_we_o,
               ram_addr_o, ram_wdata_o, e);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if ({upd_ready_o, lookup_gnt_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL full_reopen: rdy=%b gnt=%b required 1 1",
               upd_ready_o, lookup_gnt_o);
    end
    cyc();
    lookup_req_i = 1'b0;
    for (int c = 1; c < 4; c++) begin
      e = sat(1, c[0]);
      @(negedge clk);
      vectors++;
      if ({ram_we_o, ram_addr_o, ram_wdata_o} !==
          {1'b1, 6'(20 + c), e}) begin
        miscompares++;
        $display("FAIL full_order[%0d]: we=%b addr=%0d data=%0d required 1 %0d %0d",
                 c, ram_we_o, ram_addr_o, ram_wdata_o, 20 + c, e);
      end
      cyc();
    end
  endtask

  task automatic test_forward();
    logic [1:0] e;
`ifdef MOR1KX_BPU_PHT_FWD_EN
    e = sat(2, 1'b1);
`else
    e = 2'd1;
`endif
    do_init();
    lookup_req_i  = 1'b1;
    lookup_idx_i  = 6'd0;
    upd_valid_i   = 1'b1;
    upd_idx_i     = 6'd9;
    upd_old_cnt_i = 2'd2;
    upd_taken_i   = 1'b1;
    cyc();
    upd_valid_i  = 1'b0;
    lookup_idx_i = 6'd9;
    @(negedge clk);
    vectors++;
    if ({lookup_gnt_o, ram_we_o, ram_addr_o} !== {2'b10, 6'd9}) begin
      miscompares++;
      $display("FAIL fwd_gnt: gnt=%b we=%b addr=%0d required 1 0 9",
               lookup_gnt_o, ram_we_o, ram_addr_o);
    end
    cyc();
    lookup_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({lookup_valid_o, lookup_cnt_o} !== {1'b1, e}) begin
      miscompares++;
      $display("FAIL fwd_value: valid=%b cnt=%0d required 1 %0d",
               lookup_valid_o, lookup_cnt_o, e);
    end
    cyc();
  endtask

  task automatic test_ordering();
    do_init();
    lookup_req_i  = 1'b1;
    lookup_idx_i  = 6'd1;
    upd_valid_i   = 1'b1;
    upd_idx_i     = 6'd7;
    upd_old_cnt_i = 2'd1;
    upd_taken_i   = 1'b1;
    cyc();
    upd_old_cnt_i = 2'd2;
    cyc();
    upd_valid_i  = 1'b0;
    lookup_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({ram_we_o, ram_addr_o, ram_wdata_o} !==
          {1'b1, 6'd7, sat(1 + k, 1'b1)}) begin
        miscompares++;
        $display("FAIL order_write[%0d]: we=%b addr=%0d data=%0d required 1 7 %0d",
                 k, ram_we_o, ram_addr_o, ram_wdata_o, sat(1 + k, 1'b1));
      end
      cyc();
    end
    lookup_req_i = 1'b1;
    lookup_idx_i = 6'd7;
    cyc();
    lookup_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({lookup_valid_o, lookup_cnt_o} !== {1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL order_read: valid=%b cnt=%0d required 1 3",
               lookup_valid_o, lookup_cnt_o);
    end
    cyc();
  endtask

  task automatic test_random();
    bit         e_ur, e_gnt, e_pop, e_en, prev_gnt, ok;
    logic [1:0] prev_exp, last_exp, val;
    logic [IW-1:0] e_addr;
    do_init();
    prev_gnt = 1'b0;
    prev_exp = 2'b00;
    last_exp = 2'b00;
    for (int n = 0; n < 600; n++) begin
      lookup_req_i  = ($urandom_range(0, 99) < 55);
      lookup_idx_i  = 6'($urandom_range(0, 7));
      upd_valid_i   = ($urandom_range(0, 99) < 60);
      upd_idx_i     = 6'($urandom_range(0, 7));
      upd_old_cnt_i = 2'($urandom);
      upd_taken_i   = 1'($urandom);
      e_ur  = (q.size() < D);
      e_gnt = lookup_req_i && e_ur;
      e_pop = !e_gnt && (q.size() != 0);
      e_en  = e_gnt || e_pop;
      e_addr = e_gnt ? lookup_idx_i : (e_pop ? q[0].idx : '0);
      @(negedge clk);
      ok = (upd_ready_o === e_ur) && (lookup_gnt_o === e_gnt) &&
           (ram_en_o === e_en) && (ram_we_o === e_pop) &&
           (!e_en || ram_addr_o === e_addr) &&
           (!e_pop || ram_wdata_o === q[0].cnt);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rnd_arb[%0d]: rdy=%b gnt=%b en=%b we=%b addr=%0d required %b %b %b %b %0d",
                 n, upd_ready_o, lookup_gnt_o, ram_en_o, ram_we_o,
                 ram_addr_o, e_ur, e_gnt, e_en, e_pop, e_addr);
      end
      val = prev_gnt ? prev_exp : last_exp;
      vectors++;
      if (lookup_valid_o !== prev_gnt || lookup_cnt_o !== val) begin
        miscompares++;
        $display("FAIL rnd_ret[%0d]: valid=%b cnt=%0d required %b %0d",
                 n, lookup_valid_o, lookup_cnt_o, prev_gnt, val);
      end
      if (prev_gnt) last_exp = prev_exp;
      val = pht_m[lookup_idx_i];
`ifdef MOR1KX_BPU_PHT_FWD_EN
      foreach (q[k])
        if (q[k].idx == lookup_idx_i) val = q[k].cnt;
`endif
      prev_gnt = e_gnt;
      prev_exp = val;
      if (e_pop) begin
        pht_m[q[0].idx] = q[0].cnt;
        void'(q.pop_front());
      end
      if (upd_valid_i && e_ur)
        q.push_back('{idx: upd_idx_i,
                      cnt: sat(int'(upd_old_cnt_i), upd_taken_i)});
      cyc();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    cyc();
    test_reset();
    test_reset_restart();
    test_lookup_idle();
    test_saturation();
    test_full();
    test_forward();
    test_ordering();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mor1kx_bpu_pht_ctrl.md
Name: mor1kx_bpu_pht_ctrl

Overview:
- Controller and arbiter for the single-port pattern history table (PHT) RAM used by the SAT_COUNTER/GSHARE branch predictors.
- Shares one RAM port between decode-stage prediction lookups and execute-stage counter updates.
- Buffers updates in a small FIFO and clears the table after reset.
- Sits between the branch prediction logic and the PHT RAM macro.

Parameters:
- INDEX_WIDTH, 6: PHT address width; table has 2^INDEX_WIDTH 2-bit entries.
- UPD_FIFO_DEPTH, 4: update buffer entries; power of two, minimum 2.
- INIT_VALUE, 2'b01: counter value written to every entry during init (weakly not-taken).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ready_o  out  1  init sweep complete; controller accepts traffic
- lookup_req_i  in  1  decode requests a prediction read
- lookup_idx_i  in  INDEX_WIDTH  PHT index to read
- lookup_gnt_o  out  1  lookup accepted this cycle
- lookup_valid_o  out  1  lookup_cnt_o valid; one cycle after grant
- lookup_cnt_o  out  2  counter value returned
- upd_valid_i  in  1  resolved conditional branch update
- upd_idx_i  in  INDEX_WIDTH  index to update
- upd_old_cnt_i  in  2  counter value used at prediction time
- upd_taken_i  in  1  real branch outcome
- upd_ready_o  out  1  FIFO can accept an update
- ram_en_o  out  1  RAM access enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  INDEX_WIDTH  RAM address
- ram_wdata_o  out  2  RAM write data
- ram_rdata_i  in  2  RAM read data; valid one cycle after read enable

Behaviour:
- **Reset state** (rst low at clk edge): state=INIT, init counter=0, FIFO emptied, pending lookup cancelled.
  - Outputs under reset: ready_o=0, lookup_gnt_o=0, lookup_valid_o=0, lookup_cnt_o=0, upd_ready_o=0, ram_en_o=0, ram_we_o=0.
- **INIT**:
  - Each cycle drives ram_en_o=1, ram_we_o=1, ram_addr_o=init counter, ram_wdata_o=INIT_VALUE; counter increments.
  - After writing entry 2^INDEX_WIDTH-1, move to RUN. Sweep takes exactly 2^INDEX_WIDTH cycles.
  - lookup_gnt_o=0 and upd_ready_o=0 throughout.
  - A reset asserted mid-sweep restarts at index 0.
- **RUN**: ready_o=1 from the first RUN cycle; state stays RUN until reset.
- **Update push**:
  - Condition: upd_valid_i & upd_ready_o. upd_valid_i while upd_ready_o=0 is dropped; the requester is responsible for holding it.
  - Stored value is the saturating next counter: taken gives min(old+1,3); not-taken gives max(old-1,0).
  - upd_ready_o = RUN & (registered count < UPD_FIFO_DEPTH).
- **Arbitration**, one RAM access per cycle, lookup priority:
  - Lookup: if lookup_req_i and FIFO not full, grant the lookup (ram_en_o=1, ram_we_o=0, addr=lookup_idx_i, lookup_gnt_o=1).
  - Drain: else if FIFO non-empty, pop the head and write it (ram_en_o=1, ram_we_o=1). If FIFO is full, the pending lookup is refused (lookup_gnt_o=0) for that cycle.
  - Idle: else ram_en_o=0.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pointers wrap modulo UPD_FIFO_DEPTH.
- **Lookup return**: lookup_valid_o=1 exactly one cycle after lookup_gnt_o; lookup_cnt_o=ram_rdata_i unless forwarded. lookup_cnt_o holds its last value when lookup_valid_o=0.
- **Ordering**: updates retire to RAM in FIFO order. Multiple entries with the same index are all written; the youngest wins in RAM.

Optional Feature:
- Macro: MOR1KX_BPU_PHT_FWD_EN.
- Defined:
  - At grant, lookup_idx_i is compared against all valid FIFO entries (not the same-cycle push).
  - The youngest match's counter is registered and returned instead of ram_rdata_i.
  - An entry popped in the grant cycle still counts as a match.
- Undefined: lookup always returns RAM data, which may be stale by up to UPD_FIFO_DEPTH updates; no comparators.

Decomposition:
- Package mor1kx_bpu_pkg:
  - state encoding: ST_INIT, ST_RUN
  - 2-bit counter constants: STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3
  - saturating-counter next-value function
- One sub-module: mor1kx_bpu_upd_fifo.
  - Stores idx+cnt, with count, full and empty.
  - Exposes all entries for forwarding.

Test Plan:
- Reset release, INDEX_WIDTH=6 → 64 consecutive writes, addr 0..63, data 2'b01; ready_o rises at cycle 65. Reset at cycle 30 → sweep restarts at addr 0.
- Idle FIFO, lookup idx 5 → gnt same cycle; next cycle lookup_valid_o=1, lookup_cnt_o=RAM value 1.
- Saturation:
  - update idx 3, old=3, taken → RAM write 3
  - old=0, not-taken → write 0
  - old=1, taken → write 2
- Continuous lookup_req_i with 4 updates queued (full) → one cycle gnt=0 with a head write; upd_ready_o deasserts at count 4 and reasserts after the pop.
- FWD_EN defined: queue idx 9 cnt 3 (RAM still 1), lookup idx 9 → lookup_cnt_o=3. Undefined → 1.
- Two queued updates to idx 7 (values 2 then 3), lookups stalled until drained → RAM writes in order; final read of idx 7 returns 3.
